// File: rtl/stream_requant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_requant_pkg
// Purpose  : Shared helpers for the requantization datapath and its
//            downstream consumers (stream_vector_mem).
//            - sat_yw     : signed saturation bounds for a Y_W-bit result
//            - round_bit  : one bit of the round-half-up constant 2^(shift-1)
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stream_requant_pkg;

    // Upper (is_max=1) or lower (is_max=0) bound of a signed y_w-bit value.
    // Returned as a 64-bit value so callers can size-cast it to any width.
    function automatic longint sat_yw(input int y_w, input bit is_max);
        longint v_bound;
        if (is_max) begin
            v_bound = (64'sd1 <<< (y_w - 1)) - 64'sd1;
        end else begin
            v_bound = -(64'sd1 <<< (y_w - 1));
        end
        return v_bound;
    endfunction

    // Bit idx of the rounding constant added before an arithmetic right
    // shift by `shift`. The constant is 2^(shift-1), or zero for shift==0.
    // Bit-wise form lets each caller build the constant at its own width.
    function automatic logic round_bit(input int shift, input int idx);
        return (shift != 0) && (idx == shift - 1);
    endfunction

endpackage : stream_requant_pkg
`default_nettype wire

// File: rtl/stream_requant_core.sv
`default_nettype none
// ============================================================================
// Module   : requant_core
// Purpose  : Pure 3-stage requantization datapath. All stages advance
//            together when i_adv is high and hold otherwise.
//              S1: p = x * mult              (X_W+M_W bits, full precision)
//              S2: r = (p + 2^(shift-1)) >>> shift   (one bit wider)
//              S3: y = clamp(r + zp) to signed Y_W, sign-extended to X_W
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_adv        - pipeline enable
//            i_data       - signed accumulator input (X_W)
//            i_mult/i_shift/i_zp - quasi-static scale, shift, zero point
//            o_data       - stage-3 result (X_W, sign-extended)
//            o_sat        - stage-3 result was clamped
// Revision : 1.0 - initial release
// ============================================================================
module requant_core
    import stream_requant_pkg::*;
#(
    parameter int X_W     = 32,
    parameter int Y_W     = 8,
    parameter int M_W     = 16,
    parameter int SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_adv,
    input  logic [X_W-1:0]     i_data,
    input  logic [M_W-1:0]     i_mult,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic [Y_W-1:0]     i_zp,
    output logic [X_W-1:0]     o_data,
    output logic               o_sat
);

    localparam int P_W = X_W + M_W;   // full product width
    localparam int R_W = P_W + 1;     // rounding sum cannot overflow
    localparam int S_W = P_W + 2;     // zero-point sum cannot overflow

    localparam logic signed [S_W-1:0] c_SAT_HI   = S_W'(sat_yw(Y_W, 1'b1));
    localparam logic signed [S_W-1:0] c_SAT_LO   = S_W'(sat_yw(Y_W, 1'b0));
    localparam logic        [X_W-1:0] c_SAT_HI_X = X_W'(sat_yw(Y_W, 1'b1));
    localparam logic        [X_W-1:0] c_SAT_LO_X = X_W'(sat_yw(Y_W, 1'b0));

    // ---------------- Stage 1: full-precision signed multiply -------------
    logic signed [P_W-1:0] w_x_ext;
    logic signed [P_W-1:0] w_m_ext;
    logic signed [P_W-1:0] w_prod;
    logic signed [P_W-1:0] r_p;

    // Both operands sign-extended to the product width so the low P_W bits
    // of the multiply are the exact signed product.
    assign w_x_ext = {{M_W{i_data[X_W-1]}}, i_data};
    assign w_m_ext = {{X_W{i_mult[M_W-1]}}, i_mult};
    assign w_prod  = w_x_ext * w_m_ext;

    // ---------------- Stage 2: round half up, arithmetic shift ------------
    logic        [R_W-1:0] w_rc;
    logic signed [R_W-1:0] w_p_wide;
    logic signed [R_W-1:0] w_rsum;
    logic signed [R_W-1:0] w_r;
    logic signed [R_W-1:0] r_r;

    for (genvar gi = 0; gi < R_W; gi++) begin : g_rc
        assign w_rc[gi] = round_bit(int'(i_shift), gi);
    end

    assign w_p_wide = {r_p[P_W-1], r_p};
    assign w_rsum   = w_p_wide + $signed(w_rc);
    assign w_r      = w_rsum >>> i_shift;

    // ---------------- Stage 3: zero point and saturation ------------------
    logic signed [S_W-1:0] w_s;
    logic                  w_over;
    logic                  w_under;
    logic        [X_W-1:0] w_y;

    // Bounds are compared against the full-width sum, so large values can
    // never wrap into range.
    assign w_s     = {r_r[R_W-1], r_r} + {{(S_W-Y_W){i_zp[Y_W-1]}}, i_zp};
    assign w_over  = (w_s > c_SAT_HI);
    assign w_under = (w_s < c_SAT_LO);
    assign w_y     = w_over  ? c_SAT_HI_X :
                     w_under ? c_SAT_LO_X : w_s[X_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p    <= '0;
            r_r    <= '0;
            o_data <= '0;
            o_sat  <= 1'b0;
        end else if (i_adv) begin
            r_p    <= w_prod;
            r_r    <= w_r;
            o_data <= w_y;
            o_sat  <= w_over | w_under;
        end
    end

endmodule : requant_core
`default_nettype wire

// File: rtl/stream_requant.sv
`default_nettype none
// ============================================================================
// Module   : stream_requant
// Purpose  : AXI-Stream requantizer, signed X_W accumulators to signed Y_W
//            activations (sign-extended to X_W). 3-stage pipeline with a
//            single global advance; full throughput, tlast carried per beat.
// Ports    : clk, rst                   - clock, sync active-high reset
//            in_tdata/tlast/tvalid/tready   - input stream
//            out_tdata/tlast/tvalid/tready  - output stream
//            MULT, SHIFT, ZP            - quasi-static requant settings
//            busy                       - any stage holds a valid beat
//            sat_flag                   - sticky: an output beat was clamped
// Revision : 1.0 - initial release
// ============================================================================
module stream_requant
    import stream_requant_pkg::*;
#(
    parameter int X_W     = 32,
    parameter int Y_W     = 8,
    parameter int M_W     = 16,
    parameter int SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [X_W-1:0]     in_tdata,
    input  logic               in_tlast,
    input  logic               in_tvalid,
    output logic               in_tready,
    output logic [X_W-1:0]     out_tdata,
    output logic               out_tlast,
    output logic               out_tvalid,
    input  logic               out_tready,
    input  logic [M_W-1:0]     MULT,
    input  logic [SHIFT_W-1:0] SHIFT,
    input  logic [Y_W-1:0]     ZP,
    output logic               busy,
    output logic               sat_flag
);

    logic w_adv;
    logic w_sat3;
    logic r_v1, r_v2, r_v3;
    logic r_l1, r_l2, r_l3;
    logic r_sat_flag;

    // The whole pipe moves whenever the head can drain or is empty. There
    // is no skid register, so in_tready is combinational from out_tready.
    assign w_adv     = out_tready | ~r_v3;
    assign in_tready = w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_l1 <= 1'b0;
            r_l2 <= 1'b0;
            r_l3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= in_tvalid;
            r_l1 <= in_tvalid & in_tlast;
            r_v2 <= r_v1;
            r_l2 <= r_l1;
            r_v3 <= r_v2;
            r_l3 <= r_l2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
        end else if (r_v3 & out_tready & w_sat3) begin
            r_sat_flag <= 1'b1;
        end
    end

    requant_core #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .M_W     (M_W),
        .SHIFT_W (SHIFT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_adv),
        .i_data  (in_tdata),
        .i_mult  (MULT),
        .i_shift (SHIFT),
        .i_zp    (ZP),
        .o_data  (out_tdata),
        .o_sat   (w_sat3)
    );

    assign out_tvalid = r_v3;
    assign out_tlast  = r_l3;
    assign busy       = r_v1 | r_v2 | r_v3;
    assign sat_flag   = r_sat_flag;

endmodule : stream_requant
`default_nettype wire

// File: doc/stream_requant.md
# stream_requant

- Requantizes a stream of signed X_W-bit accumulator values to signed Y_W-bit activations: multiply by MULT, arithmetic right shift by SHIFT with rounding, add ZP, saturate.
- Sits directly upstream of stream_vector_mem. Its output feeds that block's in_* port 1:1: same beat count, same tlast position.
- Result is sign-extended to X_W, so downstream truncation to Y_W is lossless.
- 3-stage pipeline, AXI-Stream valid/ready, full throughput.

## Interface
Parameters:
- X_W, 32, input/output data width
- Y_W, 8, quantized result width (Y_W < X_W)
- M_W, 16, signed multiplier width
- SHIFT_W, 6, shift amount width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_tdata  in  X_W  signed accumulator value
- in_tlast  in  1  end of packet
- in_tvalid  in  1  input valid
- in_tready  out  1  input ready
- out_tdata  out  X_W  signed saturated result, sign-extended from Y_W
- out_tlast  out  1  in_tlast delayed with its beat
- out_tvalid  out  1  output valid
- out_tready  in  1  downstream ready
- MULT  in  M_W  signed scale multiplier
- SHIFT  in  SHIFT_W  unsigned right-shift amount, 0..X_W+M_W-2
- ZP  in  Y_W  signed zero point
- busy  out  1  any pipeline stage holds valid data
- sat_flag  out  1  sticky: set when any output beat saturated

## Operation
- Stage 1: p = in_tdata * MULT, full-precision signed, X_W+M_W bits.
- Stage 2: rounding and shift.
  - SHIFT==0: r = p.
  - Otherwise: r = (p + 2^(SHIFT-1)) >>> SHIFT.
  - This is round-half-up toward +inf.
  - The addition is done one bit wider, so it cannot overflow.
- Stage 3: s = r + ZP, then clamp to [-2^(Y_W-1), 2^(Y_W-1)-1].
  - out_tdata = sign-extend(clamped value).
  - Saturation is evaluated on the full-width sum, never on a truncated value.
- tlast travels alongside data through all stages (v1/l1, v2/l2, v3/l3).
- MULT, SHIFT, ZP are quasi-static: legal to change only while busy==0 and in_tvalid==0. Changing them at any other time gives undefined results for in-flight beats.
- sat_flag sets on any out handshake whose stage-3 value was clamped. It clears only on rst.

## Timing
- Reset: all stage valid bits 0, out_tvalid=0, out_tlast=0, out_tdata=0, busy=0, sat_flag=0.
- Pipeline enable: adv = out_tready | ~v3.
  - in_tready = adv. This is combinational from out_tready; there is no input register.
  - When adv=1, every stage shifts one position.
  - v1 loads in_tvalid & in_tready.
  - When adv=0, every stage holds.
- Latency: an input handshake at cycle t gives out_tvalid at t+3 (no backpressure).
- Throughput: 1 beat/cycle sustained.
- Backpressure:
  - out_tdata and out_tlast stay stable while out_tvalid & ~out_tready.
  - No beats are dropped or duplicated.
- Bubbles: an empty stage does not block. adv is global, so bubbles only collapse at the head (v3=0).
- tlast: the output beat count between tlasts equals the input count.
- busy = v1|v2|v3.
- rst mid-packet: all in-flight beats are discarded. The next accepted beat is treated as new data; no partial-packet state is retained.
- Simultaneous in and out handshakes in the same cycle are legal and are the steady state.

## Structure
- Shared package holds the saturation bounds helper (function sat_yw) and the rounding-constant function. stream_vector_mem can reuse them later.
- No typedef-based FSM; the pipeline valid bits are the only control state.
- One natural sub-module: requant_core. It is pure datapath with the enable input adv and contains stages 1–3.
- stream_requant wraps requant_core with the valid/ready, tlast, busy and sat_flag logic.

## Test plan
- Passthrough: MULT=1, SHIFT=0, ZP=0; inputs 5, -7, 127, -128 -> outputs 5, -7, 127, -128; out_tvalid 3 cycles after each accept.
- Saturation: same configuration; inputs 200, -300 -> 127, -128; sat_flag rises on the 200 beat and stays 1.
- Rounding and zero point:
  - MULT=3, SHIFT=2, ZP=0; inputs 5, -5, 2 -> 4, -4, 2 (i.e. 15→4, -15→-4, 6→2).
  - ZP=10, input 5 -> 14.
- Backpressure: 16-beat packet with out_tready toggling 1-0-0-1 randomly.
  - Output sequence equals the reference model.
  - tlast appears only on beat 16.
  - Data is held stable during stalls.
- Feed into stream_vector_mem with DIM1=2, DIM2=4: 4-beat packet of 1000, 2000, -1000, 40 with MULT=1, SHIFT=4 -> mem outputs 63, 125, -62, 3 twice, tlast on beat 8.
- Reset mid-packet: assert rst after 2 of 5 beats accepted -> next cycle out_tvalid=0, busy=0; the following 3-beat packet emerges intact with its tlast.
